bus_master_if: RTL and testbench

Initiator-side bridge between a CPU memory port (instruction fetch or MEM stage) and the eight-slave system bus. Each CPU request becomes exactly one bus transaction with a one-hot slave select, registered address, data and write-enable. The pipeline is stalled until the addressed slave acks, and the read data is held while the pipeline is frozen by other stall sources. One instance per CPU port.

---
 rtl/bus_pkg.sv | 24 ++
 rtl/bus_addr_decode.sv | 26 ++
 rtl/bus_master_if.sv | 187 ++++++++++++++++++
 tb/tb_bus_master_if.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bus_pkg.sv
// Shared definitions for the system-bus initiator bridge.
//   - FSM state encodings: IDLE / BUSY / WAIT_FOR_STALL
//   - Bus widths: data 32, address 32, select 16 (only 8 slaves populated)
//   - Address map: bit 31 set = unmapped, bits 30:28 = slave index
//   - Default ack timeout (used only when BUS_TIMEOUT_EN is defined)
package bus_pkg;

  localparam int unsigned WB_DataBus   = 32;
  localparam int unsigned WB_AddrBus   = 32;
  localparam int unsigned WB_SelectBus = 16;

  localparam int unsigned SLAVE_IDX_HI = 30;
  localparam int unsigned SLAVE_IDX_LO = 28;
  localparam int unsigned UNMAPPED_BIT = 31;

  localparam int unsigned DEF_TIMEOUT_CYCLES = 255;

  typedef enum logic [1:0] {
    IDLE           = 2'd0,
    BUSY           = 2'd1,
    WAIT_FOR_STALL = 2'd2
  } bus_state_e;

endpackage

// File: rtl/bus_addr_decode.sv
// Combinational slave decoder.
// Ports:
//   addr_i      byte address from the CPU
//   sel_o       one-hot slave select (bits 15:8 always 0); all-zero if unmapped
//   unmapped_o  1 when addr_i[31] is set
module bus_addr_decode
  import bus_pkg::*;
(
  input  logic [WB_AddrBus-1:0]   addr_i,
  output logic [WB_SelectBus-1:0] sel_o,
  output logic                    unmapped_o
);

  // Only the top nibble participates in decoding.
  logic unused_addr_bits;
  assign unused_addr_bits = ^addr_i[SLAVE_IDX_LO-1:0];

  always_comb begin
    unmapped_o = addr_i[UNMAPPED_BIT];
    sel_o      = '0;
    if (!unmapped_o) begin
      sel_o = {{(WB_SelectBus-1){1'b0}}, 1'b1} << addr_i[SLAVE_IDX_HI:SLAVE_IDX_LO];
    end
  end

endmodule

// File: rtl/bus_master_if.sv
// Initiator bridge from one CPU memory port to the eight-slave system bus.
// One CPU request becomes one registered bus transaction; the pipeline is
// stalled until the slave acks, and the returned data is held in rd_buf while
// the pipeline stays frozen by other stall sources.
//
// Optional feature: define BUS_TIMEOUT_EN to abort a transaction with data 0
// and a one-cycle bus_err_o pulse after TIMEOUT_CYCLES un-acked BUSY cycles.
//
// Ports:
//   clk, rst            clock, synchronous active-low reset
//   cpu_ce_i/we_i       CPU request valid / write
//   cpu_addr_i/data_i   CPU address / write data
//   cpu_data_o          read data to CPU (combinational on ack)
//   stall_req_o         pipeline stall request (combinational)
//   stall_i, flush_i    pipeline frozen / pipeline flush
//   bus_err_o           timeout error pulse
//   m_addr_o/data_o/we_o/select_o  registered bus outputs
//   m_data_i, m_ack_i   bus read data / ack
module bus_master_if
  import bus_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cpu_ce_i,
  input  logic                    cpu_we_i,
  input  logic [WB_AddrBus-1:0]   cpu_addr_i,
  input  logic [WB_DataBus-1:0]   cpu_data_i,
  output logic [WB_DataBus-1:0]   cpu_data_o,
  output logic                    stall_req_o,
  input  logic                    stall_i,
  input  logic                    flush_i,
  output logic                    bus_err_o,
  output logic [WB_AddrBus-1:0]   m_addr_o,
  output logic [WB_DataBus-1:0]   m_data_o,
  output logic                    m_we_o,
  output logic [WB_SelectBus-1:0] m_select_o,
  input  logic [WB_DataBus-1:0]   m_data_i,
  input  logic                    m_ack_i
);

  bus_state_e state_q, state_d;

  logic [WB_AddrBus-1:0]   addr_q, addr_d;
  logic [WB_DataBus-1:0]   wdata_q, wdata_d;
  logic [WB_DataBus-1:0]   rd_buf_q, rd_buf_d;
  logic                    we_q, we_d;
  logic [WB_SelectBus-1:0] sel_q, sel_d;
  logic                    unmapped_q, unmapped_d;

  logic [WB_SelectBus-1:0] dec_sel;
  logic                    dec_unmapped;

  logic                  accept;
  logic                  ack_hit;
  logic                  timeout_hit;
  logic                  done;
  logic [WB_DataBus-1:0] resp_data;

  bus_addr_decode u_decode (
    .addr_i     (cpu_addr_i),
    .sel_o      (dec_sel),
    .unmapped_o (dec_unmapped)
  );

  assign accept  = (state_q == IDLE) && cpu_ce_i && !flush_i;
  // A slave ack is meaningless for an unmapped access; nobody was selected.
  assign ack_hit = (state_q == BUSY) && m_ack_i && !unmapped_q;
  assign done    = (state_q == BUSY) && (m_ack_i || unmapped_q || timeout_hit);

  // Only an acked read returns bus data; writes, unmapped and timeouts give 0.
  assign resp_data = (ack_hit && !we_q) ? m_data_i : '0;

`ifdef BUS_TIMEOUT_EN
  localparam int unsigned CNT_W =
    ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // cnt_q counts completed un-acked BUSY cycles, so the Nth such cycle sees N-1.
  assign timeout_hit = (state_q == BUSY) && !m_ack_i && !unmapped_q &&
                       (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
  assign bus_err_o   = timeout_hit;

  always_comb begin
    cnt_d = cnt_q;
    if (accept) begin
      cnt_d = '0;
    end else if ((state_q == BUSY) && !m_ack_i) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`else
  logic unused_timeout_param;
  assign unused_timeout_param = ^TIMEOUT_CYCLES;
  assign timeout_hit          = 1'b0;
  assign bus_err_o            = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    we_d        = we_q;
    sel_d       = sel_q;
    unmapped_d  = unmapped_q;
    rd_buf_d    = rd_buf_q;
    stall_req_o = 1'b0;
    cpu_data_o  = '0;

    unique case (state_q)
      IDLE: begin
        stall_req_o = cpu_ce_i && !flush_i;
        if (accept) begin
          addr_d     = cpu_addr_i;
          wdata_d    = cpu_data_i;
          we_d       = cpu_we_i;
          sel_d      = dec_sel;
          unmapped_d = dec_unmapped;
          state_d    = BUSY;
        end
      end

      BUSY: begin
        if (done) begin
          cpu_data_o = flush_i ? '0 : resp_data;
          rd_buf_d   = resp_data;
          sel_d      = '0;
          we_d       = 1'b0;
          state_d    = (stall_i && !flush_i) ? WAIT_FOR_STALL : IDLE;
        end else if (flush_i) begin
          sel_d   = '0;
          we_d    = 1'b0;
          state_d = IDLE;
        end else begin
          stall_req_o = 1'b1;
        end
      end

      WAIT_FOR_STALL: begin
        cpu_data_o = flush_i ? '0 : rd_buf_q;
        if (!stall_i || flush_i) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      wdata_q    <= '0;
      we_q       <= 1'b0;
      sel_q      <= '0;
      unmapped_q <= 1'b0;
      rd_buf_q   <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      we_q       <= we_d;
      sel_q      <= sel_d;
      unmapped_q <= unmapped_d;
      rd_buf_q   <= rd_buf_d;
    end
  end

  assign m_addr_o   = addr_q;
  assign m_data_o   = wdata_q;
  assign m_we_o     = we_q;
  assign m_select_o = sel_q;

endmodule

// File: tb/tb_bus_master_if.sv
// Directed bench for bus_master_if. The driver pushes the expected CPU-side
// response (data, error flag) into a queue before the completing cycle; the
// monitor pops and compares whenever the CPU sees its request finish
// (cpu_ce_i high, stall_req_o low, no flush). Bus-side timing is checked
// directly by the driver on the falling edge.
module tb_bus_master_if;

  typedef struct packed {
    logic [31:0] data;
    logic        err;
  } resp_t;

  logic        clk;
  logic        rst;
  logic        cpu_ce_i;
  logic        cpu_we_i;
  logic [31:0] cpu_addr_i;
  logic [31:0] cpu_data_i;
  logic [31:0] cpu_data_o;
  logic        stall_req_o;
  logic        stall_i;
  logic        flush_i;
  logic        bus_err_o;
  logic [31:0] m_addr_o;
  logic [31:0] m_data_o;
  logic        m_we_o;
  logic [15:0] m_select_o;
  logic [31:0] m_data_i;
  logic        m_ack_i;

  resp_t exp_q[$];
  int    vectors = 0;
  int    fails   = 0;

`ifdef BUS_TIMEOUT_EN
  localparam int unsigned TMO = 4;
`else
  localparam int unsigned TMO = 255;
`endif

  bus_master_if #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk         (clk),
    .rst         (rst),
    .cpu_ce_i    (cpu_ce_i),
    .cpu_we_i    (cpu_we_i),
    .cpu_addr_i  (cpu_addr_i),
    .cpu_data_i  (cpu_data_i),
    .cpu_data_o  (cpu_data_o),
    .stall_req_o (stall_req_o),
    .stall_i     (stall_i),
    .flush_i     (flush_i),
    .bus_err_o   (bus_err_o),
    .m_addr_o    (m_addr_o),
    .m_data_o    (m_data_o),
    .m_we_o      (m_we_o),
    .m_select_o  (m_select_o),
    .m_data_i    (m_data_i),
    .m_ack_i     (m_ack_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Drive just after the rising edge, sample on the falling edge.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic push(input logic [31:0] d, input logic e);
    resp_t r;
    r.data = d;
    r.err  = e;
    exp_q.push_back(r);
  endtask

  // Monitor: one response per completed CPU request.
  always @(negedge clk) begin
    if (rst && cpu_ce_i && !stall_req_o && !flush_i) begin
      if (exp_q.size() == 0) begin
        vectors++;
        fails++;
        $display("FAIL resp_unexpected: got data 0x%08h err %0b, expected no response",
                 cpu_data_o, bus_err_o);
      end else begin
        resp_t r;
        r = exp_q.pop_front();
        chk("resp_data", cpu_data_o, r.data);
        chk("resp_err", {31'd0, bus_err_o}, {31'd0, r.err});
      end
    end
  end

  initial begin
    rst        = 1'b0;
    cpu_ce_i   = 1'b0;
    cpu_we_i   = 1'b0;
    cpu_addr_i = '0;
    cpu_data_i = '0;
    stall_i    = 1'b0;
    flush_i    = 1'b0;
    m_data_i   = '0;
    m_ack_i    = 1'b0;

    // ---- Reset state ----
    repeat (3) next_cycle();
    sample();
    chk("rst_sel", {16'd0, m_select_o}, 32'h0);
    chk("rst_addr", m_addr_o, 32'h0);
    chk("rst_wdata", m_data_o, 32'h0);
    chk("rst_we", {31'd0, m_we_o}, 32'h0);
    chk("rst_err", {31'd0, bus_err_o}, 32'h0);
    chk("rst_stall", {31'd0, stall_req_o}, 32'h0);
    chk("rst_cpu_data", cpu_data_o, 32'h0);
    next_cycle();
    rst = 1'b1;

    // ---- Read 0x2000_0010, ack on third BUSY cycle ----
    next_cycle();
    cpu_ce_i = 1'b1; cpu_we_i = 1'b0; cpu_addr_i = 32'h2000_0010;
    sample();
    chk("rd_c0_stall", {31'd0, stall_req_o}, 32'h1);
    chk("rd_c0_sel", {16'd0, m_select_o}, 32'h0);
    for (int c = 1; c <= 2; c++) begin
      next_cycle();
      sample();
      chk("rd_busy_sel", {16'd0, m_select_o}, 32'h0004);
      chk("rd_busy_addr", m_addr_o, 32'h2000_0010);
      chk("rd_busy_stall", {31'd0, stall_req_o}, 32'h1);
    end
    next_cycle();
    m_ack_i = 1'b1; m_data_i = 32'hDEAD_BEEF;
    push(32'hDEAD_BEEF, 1'b0);
    sample();
    chk("rd_c3_stall", {31'd0, stall_req_o}, 32'h0);
    next_cycle();
    cpu_ce_i = 1'b0; m_ack_i = 1'b0;
    sample();
    chk("rd_c4_sel", {16'd0, m_select_o}, 32'h0);

    // ---- Write 0x7000_0000 = 0x12345678, ack on second BUSY cycle ----
    next_cycle();
    cpu_ce_i = 1'b1; cpu_we_i = 1'b1; cpu_addr_i = 32'h7000_0000; cpu_data_i = 32'h1234_5678;
    next_cycle();
    cpu_data_i = 32'hFFFF_FFFF;
    sample();
    chk("wr_sel", {16'd0, m_select_o}, 32'h0080);
    chk("wr_we", {31'd0, m_we_o}, 32'h1);
    chk("wr_wdata", m_data_o, 32'h1234_5678);
    next_cycle();
    m_ack_i = 1'b1; m_data_i = 32'hAAAA_AAAA;
    push(32'h0, 1'b0);
    sample();
    chk("wr_ack_we", {31'd0, m_we_o}, 32'h1);
    next_cycle();
    cpu_ce_i = 1'b0; cpu_we_i = 1'b0; m_ack_i = 1'b0;
    sample();
    chk("wr_after_we", {31'd0, m_we_o}, 32'h0);
    chk("wr_after_sel", {16'd0, m_select_o}, 32'h0);

    // ---- Unmapped read 0x8000_0000: completes in cycle 1 with 0 ----
    next_cycle();
    cpu_ce_i = 1'b1; cpu_addr_i = 32'h8000_0000; m_data_i = 32'hFFFF_FFFF;
    push(32'h0, 1'b0);
    next_cycle();
    sample();
    chk("um_sel", {16'd0, m_select_o}, 32'h0);
    chk("um_stall", {31'd0, stall_req_o}, 32'h0);
    next_cycle();
    cpu_ce_i = 1'b0;
    sample();
    chk("um_c2_sel", {16'd0, m_select_o}, 32'h0);

    // ---- Ack under external stall: data held through WAIT_FOR_STALL ----
    next_cycle();
    cpu_ce_i = 1'b1; cpu_addr_i = 32'h1000_0004;
    next_cycle();
    m_ack_i = 1'b1; m_data_i = 32'hCAFE_F00D; stall_i = 1'b1;
    push(32'hCAFE_F00D, 1'b0);
    sample();
    chk("st_sel", {16'd0, m_select_o}, 32'h0002);
    for (int c = 0; c < 3; c++) begin
      next_cycle();
      cpu_ce_i = 1'b0; m_ack_i = 1'b0; m_data_i = 32'h0BAD_BAD0;
      sample();
      chk("st_hold_data", cpu_data_o, 32'hCAFE_F00D);
      chk("st_hold_stall", {31'd0, stall_req_o}, 32'h0);
      chk("st_hold_sel", {16'd0, m_select_o}, 32'h0);
    end
    next_cycle();
    stall_i = 1'b0;
    sample();
    chk("st_release_data", cpu_data_o, 32'hCAFE_F00D);
    next_cycle();
    sample();
    chk("st_idle_data", cpu_data_o, 32'h0);

    // ---- Flush in cycle 2 of a pending read; later ack ignored ----
    next_cycle();
    cpu_ce_i = 1'b1; cpu_addr_i = 32'h3000_0000;
    next_cycle();
    sample();
    chk("fl_sel", {16'd0, m_select_o}, 32'h0008);
    next_cycle();
    flush_i = 1'b1;
    sample();
    chk("fl_stall", {31'd0, stall_req_o}, 32'h0);
    chk("fl_data", cpu_data_o, 32'h0);
    next_cycle();
    flush_i = 1'b0; cpu_ce_i = 1'b0;
    sample();
    chk("fl_c3_sel", {16'd0, m_select_o}, 32'h0);
    next_cycle();
    m_ack_i = 1'b1; m_data_i = 32'h5555_5555;
    sample();
    chk("fl_late_stall", {31'd0, stall_req_o}, 32'h0);
    chk("fl_late_data", cpu_data_o, 32'h0);
    chk("fl_late_sel", {16'd0, m_select_o}, 32'h0);
    next_cycle();
    m_ack_i = 1'b0;

    // ---- Back-to-back: second request starts from IDLE after the ack ----
    next_cycle();
    cpu_ce_i = 1'b1; cpu_addr_i = 32'h0000_0000;
    next_cycle();
    m_ack_i = 1'b1; m_data_i = 32'h1111_1111;
    push(32'h1111_1111, 1'b0);
    sample();
    chk("bb_sel1", {16'd0, m_select_o}, 32'h0001);
    next_cycle();
    m_ack_i = 1'b0; cpu_addr_i = 32'h4000_0008;
    sample();
    chk("bb_gap_sel", {16'd0, m_select_o}, 32'h0);
    chk("bb_gap_stall", {31'd0, stall_req_o}, 32'h1);
    next_cycle();
    m_ack_i = 1'b1; m_data_i = 32'h2222_2222;
    push(32'h2222_2222, 1'b0);
    sample();
    chk("bb_sel2", {16'd0, m_select_o}, 32'h0010);
    chk("bb_addr2", m_addr_o, 32'h4000_0008);
    next_cycle();
    cpu_ce_i = 1'b0; m_ack_i = 1'b0;
    sample();
    chk("bb_end_sel", {16'd0, m_select_o}, 32'h0);

    // ---- Reset asserted mid-BUSY ----
    next_cycle();
    cpu_ce_i = 1'b1; cpu_we_i = 1'b1; cpu_addr_i = 32'h5000_0000; cpu_data_i = 32'hA5A5_A5A5;
    next_cycle();
    sample();
    chk("mr_sel", {16'd0, m_select_o}, 32'h0020);
    next_cycle();
    rst = 1'b0; cpu_ce_i = 1'b0; cpu_we_i = 1'b0;
    next_cycle();
    rst = 1'b1;
    sample();
    chk("mr_sel0", {16'd0, m_select_o}, 32'h0);
    chk("mr_we0", {31'd0, m_we_o}, 32'h0);
    chk("mr_addr0", m_addr_o, 32'h0);
    chk("mr_wdata0", m_data_o, 32'h0);
    chk("mr_stall0", {31'd0, stall_req_o}, 32'h0);
    chk("mr_data0", cpu_data_o, 32'h0);

`ifdef BUS_TIMEOUT_EN
    // ---- Timeout after 4 un-acked BUSY cycles ----
    next_cycle();
    cpu_ce_i = 1'b1; cpu_addr_i = 32'h6000_0000; m_data_i = 32'h9999_9999;
    push(32'h0, 1'b1);
    for (int c = 1; c <= 3; c++) begin
      next_cycle();
      sample();
      chk("to_wait_err", {31'd0, bus_err_o}, 32'h0);
      chk("to_wait_stall", {31'd0, stall_req_o}, 32'h1);
    end
    next_cycle();
    sample();
    chk("to_hit_stall", {31'd0, stall_req_o}, 32'h0);
    next_cycle();
    cpu_ce_i = 1'b0;
    sample();
    chk("to_after_err", {31'd0, bus_err_o}, 32'h0);
    chk("to_after_sel", {16'd0, m_select_o}, 32'h0);
`else
    // ---- No timeout: a slow slave keeps the pipeline stalled ----
    next_cycle();
    cpu_ce_i = 1'b1; cpu_addr_i = 32'h6000_0000; m_data_i = 32'h9999_9999;
    for (int c = 1; c <= 6; c++) begin
      next_cycle();
      sample();
      chk("slow_err", {31'd0, bus_err_o}, 32'h0);
      chk("slow_stall", {31'd0, stall_req_o}, 32'h1);
    end
    next_cycle();
    m_ack_i = 1'b1; m_data_i = 32'h7777_7777;
    push(32'h7777_7777, 1'b0);
    sample();
    chk("slow_sel", {16'd0, m_select_o}, 32'h0040);
    next_cycle();
    cpu_ce_i = 1'b0; m_ack_i = 1'b0;
`endif

    repeat (2) next_cycle();
    sample();
    chk("queue_drained", exp_q.size(), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule
